// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the counter command controller.
//   - default debounce / auto-repeat timing
//   - repeat FSM state encoding
//   - command pulse bundle and button index map
//   - cw(): counter width helper (never returns 0)
package counter_pkg;

  localparam int DEB_CYCLES_DEF   = 16;
  localparam int REPEAT_DELAY_DEF = 64;
  localparam int REPEAT_RATE_DEF  = 8;

  // Bit positions inside the packed button vectors.
  localparam int B_LOAD = 0;
  localparam int B_UP   = 1;
  localparam int B_DN   = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HOLD_WAIT = 2'd1,
    ST_REPEAT    = 2'd2
  } rpt_state_e;

  typedef struct packed {
    logic load;
    logic down;
    logic up;
  } cmd_t;

  // Width able to hold 0..n-1; at least one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer followed by a stable-level debouncer.
//   clk   : clock
//   rst   : async active-high reset
//   btn   : raw asynchronous button
//   level : debounced level; follows the synchronized input once it has
//           disagreed with the current level for DEB_CYCLES consecutive edges
module btn_debounce
  import counter_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level
);

  localparam int CW = cw(DEB_CYCLES);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Any sample agreeing with the current level restarts the count, so a
  // glitch shorter than DEB_CYCLES never reaches the flip point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (s2 == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      level <= s2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/counter_cmd_ctrl.sv
// counter_cmd_ctrl: turns three bouncing push-buttons into single-cycle
// LOAD / UP / DOWN command pulses for a 5-bit counter, with hold-to-repeat
// on UP/DOWN.
//   CLK, RST             : clock, async active-high reset
//   BTN_LOAD/UP/DOWN     : raw buttons, high = pressed
//   SW[4:0]              : raw load-value switches
//   FLAG_High / FLAG_LOW : counter is at 31 / at 0 (blocks UP / DOWN pulses)
//   LOAD, UP, DOWN       : registered one-hot command pulses
//   IN[4:0]              : load value, updated together with LOAD
module counter_cmd_ctrl
  import counter_pkg::*;
#(
  parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_LOAD,
  input  logic       BTN_UP,
  input  logic       BTN_DOWN,
  input  logic [4:0] SW,
  input  logic       FLAG_High,
  input  logic       FLAG_LOW,
  output logic       LOAD,
  output logic       UP,
  output logic       DOWN,
  output logic [4:0] IN
);

  localparam int WW = cw(REPEAT_DELAY);
  localparam int RW = cw(REPEAT_RATE);

  logic [2:0]    btn_raw, deb_lvl, deb_q, deb_rise;
  logic [4:0]    sw_s1, sw_s2;
  rpt_state_e    state, state_nxt;
  logic          dir_dn, dir_dn_nxt;   // latched direction, 1 = DOWN
  logic [WW-1:0] wait_tmr;
  logic [RW-1:0] rate_tmr;
  logic          held, wait_done, rate_done, fire, blocked;
  cmd_t          cmd_nxt;

  assign btn_raw = {BTN_DOWN, BTN_UP, BTN_LOAD};

  for (genvar i = 0; i < 3; i++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk  (CLK),
      .rst  (RST),
      .btn  (btn_raw[i]),
      .level(deb_lvl[i])
    );
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      deb_q <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      deb_q <= deb_lvl;
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
    end
  end

  // Rise strobes: one cycle, the cycle after the debounced level goes high.
  assign deb_rise  = deb_lvl & ~deb_q;
  assign held      = dir_dn ? deb_lvl[B_DN] : deb_lvl[B_UP];
  assign wait_done = (wait_tmr == WW'(REPEAT_DELAY - 1));
  assign rate_done = (rate_tmr == RW'(REPEAT_RATE - 1));

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_IDLE;
      dir_dn <= 1'b0;
    end else begin
      state  <= state_nxt;
      dir_dn <= dir_dn_nxt;
    end
  end

  // Next state. LOAD wins over everything; DOWN beats UP when both rise in
  // IDLE. Outside IDLE every UP/DOWN rise is dropped.
  always_comb begin
    state_nxt  = state;
    dir_dn_nxt = dir_dn;
    if (deb_rise[B_LOAD]) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (deb_rise[B_DN]) begin
            state_nxt  = ST_HOLD_WAIT;
            dir_dn_nxt = 1'b1;
          end else if (deb_rise[B_UP]) begin
            state_nxt  = ST_HOLD_WAIT;
            dir_dn_nxt = 1'b0;
          end
        end
        ST_HOLD_WAIT: begin
          if (!held)          state_nxt = ST_IDLE;
          else if (wait_done) state_nxt = ST_REPEAT;
        end
        ST_REPEAT: begin
          if (!held) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs. The flags only mask the pulse; sequencing is unaffected so a
  // cleared flag picks up on the next repeat slot.
  always_comb begin
    cmd_nxt = '0;
    fire    = 1'b0;
    if (deb_rise[B_LOAD]) begin
      cmd_nxt.load = 1'b1;
    end else begin
      case (state)
        ST_IDLE:      fire = deb_rise[B_DN] | deb_rise[B_UP];
        ST_HOLD_WAIT: fire = held & wait_done;
        ST_REPEAT:    fire = held & rate_done;
        default:      fire = 1'b0;
      endcase
    end
    blocked = dir_dn_nxt ? FLAG_LOW : FLAG_High;
    if (fire && !blocked) begin
      cmd_nxt.down = dir_dn_nxt;
      cmd_nxt.up   = ~dir_dn_nxt;
    end
  end

  // Each timer only counts while its state persists and is cleared on every
  // entry or slot, so it never exceeds its terminal value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_tmr <= '0;
      rate_tmr <= '0;
    end else begin
      wait_tmr <= (state == ST_HOLD_WAIT && state_nxt == ST_HOLD_WAIT)
                  ? wait_tmr + WW'(1) : '0;
      rate_tmr <= (state == ST_REPEAT && state_nxt == ST_REPEAT && !rate_done)
                  ? rate_tmr + RW'(1) : '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      LOAD <= 1'b0;
      UP   <= 1'b0;
      DOWN <= 1'b0;
      IN   <= '0;
    end else begin
      LOAD <= cmd_nxt.load;
      UP   <= cmd_nxt.up;
      DOWN <= cmd_nxt.down;
      if (cmd_nxt.load) IN <= sw_s2;
    end
  end

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Bench for counter_cmd_ctrl: directed scenarios plus random button/flag
// traffic, checked every cycle against a behavioural model. The model
// debounces with a sliding window over raw-sample history and derives pulse
// times arithmetically from the press-accept edge.
module tb_counter_cmd_ctrl;

  localparam int DEB  = 16;
  localparam int DLY  = 64;
  localparam int RATE = 8;

  logic       CLK = 1'b0;
  logic       RST, BTN_LOAD, BTN_UP, BTN_DOWN, FLAG_High, FLAG_LOW;
  logic [4:0] SW;
  logic       LOAD, UP, DOWN;
  logic [4:0] IN;

  counter_cmd_ctrl #(.DEB_CYCLES(DEB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)) dut (
    .CLK(CLK), .RST(RST), .BTN_LOAD(BTN_LOAD), .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN),
    .SW(SW), .FLAG_High(FLAG_High), .FLAG_LOW(FLAG_LOW),
    .LOAD(LOAD), .UP(UP), .DOWN(DOWN), .IN(IN)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [2:0] rawh [0:DEB+1];   // [0] = buttons sampled at this edge
  logic [4:0] swh  [0:2];
  logic [2:0] m_deb, m_rise;    // {down, up, load}
  bit         m_act, m_dir_dn;
  int         m_t0, m_edge;
  logic       e_load, e_up, e_dn;
  logic [4:0] e_in;

  task automatic model_reset();
    for (int i = 0; i <= DEB + 1; i++) rawh[i] = '0;
    for (int i = 0; i < 3; i++) swh[i] = '0;
    m_deb = '0; m_rise = '0; m_act = 0; m_dir_dn = 0; m_t0 = 0; m_edge = 0;
    e_load = 0; e_up = 0; e_dn = 0; e_in = '0;
  endtask

  task automatic model_edge();
    logic [2:0] nr;
    bit held, flip;
    int k;
    m_edge++;
    for (int i = DEB + 1; i > 0; i--) rawh[i] = rawh[i-1];
    rawh[0] = {BTN_DOWN, BTN_UP, BTN_LOAD};
    swh[2] = swh[1]; swh[1] = swh[0]; swh[0] = SW;
    e_load = 0; e_up = 0; e_dn = 0;
    if (m_rise[0]) begin
      e_load = 1; e_in = swh[2]; m_act = 0;
    end else if (m_act) begin
      held = m_dir_dn ? m_deb[2] : m_deb[1];
      if (!held) m_act = 0;
      else begin
        k = m_edge - m_t0;
        if (k >= DLY && (k - DLY) % RATE == 0) begin
          if (m_dir_dn) e_dn = !FLAG_LOW; else e_up = !FLAG_High;
        end
      end
    end else if (m_rise[2]) begin
      m_act = 1; m_dir_dn = 1; m_t0 = m_edge; e_dn = !FLAG_LOW;
    end else if (m_rise[1]) begin
      m_act = 1; m_dir_dn = 0; m_t0 = m_edge; e_up = !FLAG_High;
    end
    // Level flips once the last DEB synchronized samples all disagree.
    nr = '0;
    for (int b = 0; b < 3; b++) begin
      flip = 1;
      for (int i = 2; i <= DEB + 1; i++) if (rawh[i][b] == m_deb[b]) flip = 0;
      if (flip) begin
        m_deb[b] = ~m_deb[b];
        nr[b] = m_deb[b];
      end
    end
    m_rise = nr;
  endtask

  // ---------------- cycle driver ----------------
  int c_load, c_up, c_dn, p_edge;
  int up_rel[$], dn_rel[$];

  task automatic tick();
    @(posedge CLK);
    if (!RST) model_edge();
    #1;
    if (RST) chk("rst_out", 32'({LOAD, UP, DOWN, IN}), 0);
    else begin
      chk("load", 32'(LOAD), 32'(e_load));
      chk("up", 32'(UP), 32'(e_up));
      chk("down", 32'(DOWN), 32'(e_dn));
      chk("in", 32'(IN), 32'(e_in));
      chk("onehot", 32'($countones({LOAD, UP, DOWN}) <= 1), 1);
    end
    c_load += int'(LOAD); c_up += int'(UP); c_dn += int'(DOWN);
    if (UP)   up_rel.push_back(m_edge - p_edge + 1);
    if (DOWN) dn_rel.push_back(m_edge - p_edge + 1);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int late, drop, base, slot, rlen;
  logic [2:0] rb, rg;

  initial begin
    RST = 0; BTN_LOAD = 0; BTN_UP = 0; BTN_DOWN = 0; SW = '0;
    FLAG_High = 0; FLAG_LOW = 0; p_edge = 0;
    c_load = 0; c_up = 0; c_dn = 0;
    model_reset();
    #2 RST = 1;
    #1 chk("rst_async", 32'({LOAD, UP, DOWN, IN}), 0);
    hold(3);
    RST = 0;
    hold(5);

    // Bouncy LOAD press, then a clean hold
    SW = 5'd19; c_load = 0;
    for (int i = 0; i < 5; i++) begin
      BTN_LOAD = 1; hold(3); BTN_LOAD = 0; hold(3);
    end
    BTN_LOAD = 1; hold(40); BTN_LOAD = 0; SW = 5'd4; hold(40);
    chk("bounce_loads", 32'(c_load), 1);
    chk("bounce_in", 32'(IN), 19);

    // UP held 100 cycles
    up_rel.delete(); p_edge = m_edge + 1;
    BTN_UP = 1; hold(100); BTN_UP = 0; hold(40);
    chk("up_p1", 32'(up_rel.size() > 0 ? up_rel[0] : 0), DEB + 3);
    chk("up_p2", 32'(up_rel.size() > 1 ? up_rel[1] : 0), DEB + 3 + DLY);
    chk("up_p3", 32'(up_rel.size() > 2 ? up_rel[2] : 0), DEB + 3 + DLY + RATE);
    late = 0;
    foreach (up_rel[i]) if (up_rel[i] > 100 + DEB + 2) late++;
    chk("up_after_release", 32'(late), 0);

    // DOWN held at zero, then flag drops while repeating
    FLAG_LOW = 1; dn_rel.delete(); p_edge = m_edge + 1;
    BTN_DOWN = 1; hold(120);
    chk("down_blocked", 32'(dn_rel.size()), 0);
    FLAG_LOW = 0; drop = m_edge - p_edge + 2;
    hold(30); BTN_DOWN = 0; hold(40);
    base = DEB + 3 + DLY;
    slot = (drop <= base) ? base : base + ((drop - base + RATE - 1) / RATE) * RATE;
    chk("down_resume", 32'(dn_rel.size() > 0 ? dn_rel[0] : 0), 32'(slot));

    // Simultaneous presses
    c_load = 0; c_up = 0; c_dn = 0; SW = 5'd7;
    BTN_LOAD = 1; BTN_UP = 1; BTN_DOWN = 1; hold(40);
    BTN_LOAD = 0; BTN_UP = 0; BTN_DOWN = 0; hold(40);
    chk("all3_load", 32'(c_load), 1);
    chk("all3_up", 32'(c_up), 0);
    chk("all3_down", 32'(c_dn), 0);
    chk("all3_in", 32'(IN), 7);
    c_load = 0; c_up = 0; c_dn = 0;
    BTN_UP = 1; BTN_DOWN = 1; hold(40);
    BTN_UP = 0; BTN_DOWN = 0; hold(40);
    chk("updn_down", 32'(c_dn), 1);
    chk("updn_up", 32'(c_up), 0);

    // Short glitch
    c_up = 0;
    BTN_UP = 1; hold(10); BTN_UP = 0; hold(40);
    chk("glitch_up", 32'(c_up), 0);

    // Reset in the middle of auto-repeat, button kept down
    p_edge = m_edge + 1; BTN_UP = 1; hold(99);
    chk("pre_rst_up", 32'(UP), 1);
    #2 RST = 1; model_reset();
    #1 chk("rst_immediate", 32'({LOAD, UP, DOWN}), 0);
    hold(3);
    RST = 0; up_rel.delete(); p_edge = m_edge + 1;
    hold(40);
    chk("post_rst_cnt", 32'(up_rel.size()), 1);
    chk("post_rst_at", 32'(up_rel.size() > 0 ? up_rel[0] : 0), DEB + 3);
    BTN_UP = 0; hold(40);

    // Random traffic
    for (int s = 0; s < 40; s++) begin
      rb = 3'($urandom_range(0, 7));
      rlen = $urandom_range(1, 150);
      if (s == 20) begin
        #2 RST = 1; model_reset();
        hold(2);
        RST = 0;
      end
      for (int i = 0; i < rlen; i++) begin
        rg = '0;
        if ($urandom_range(0, 24) == 0) rg = 3'(1 << $urandom_range(0, 2));
        {BTN_DOWN, BTN_UP, BTN_LOAD} = rb ^ rg;
        SW = 5'($urandom);
        if ($urandom_range(0, 15) == 0) FLAG_High = ~FLAG_High;
        if ($urandom_range(0, 15) == 0) FLAG_LOW = ~FLAG_LOW;
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
